// File: rtl/prbs_checker_23b.sv
// Serial PRBS checker: self-synchronises a local x^23 + x^18 + 1 LFSR to the received
// stream, then free-runs it to count bit errors and detect loss of lock.
module prbs_checker_23b #(
    parameter int WIDTH       = 23,
    parameter int TAP         = 18,
    parameter int SYNC_LEN    = 64,
    parameter int LOSS_WINDOW = 256,
    parameter int LOSS_THRESH = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_enable,
    input  logic             bit_in,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic             lol_pulse,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] ST_SEED   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(SYNC_LEN + 1);
    localparam int WIN_W   = $clog2(LOSS_WINDOW);
    localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
    localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(SYNC_LEN);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(LOSS_WINDOW - 1);
    localparam logic [WERR_W-1:0]  WERR_LIMIT = WERR_W'(LOSS_THRESH);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [WERR_W-1:0]  werr_q, werr_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               err_pulse_q, err_pulse_d;
    logic               lol_pulse_q, lol_pulse_d;

    logic               pred;
    logic               mismatch;
    logic [WERR_W-1:0]  werr_next;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_d       = win_q;
        werr_d      = werr_q;
        bit_cnt_d   = bit_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        lol_pulse_d = 1'b0;
        pred        = sr_q[WIDTH-1] ^ sr_q[TAP-1];
        mismatch    = (bit_in != pred);
        werr_next   = werr_q + WERR_W'(mismatch);

        if (shift_enable) begin
            case (state_q)
                ST_SEED: begin
                    sr_d = {sr_q[WIDTH-2:0], bit_in};
                    if (fill_q == FILL_LAST) begin
                        fill_d  = '0;
                        match_d = '0;
                        state_d = ST_VERIFY;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                ST_VERIFY: begin
                    sr_d = {sr_q[WIDTH-2:0], bit_in};
                    if (mismatch) begin
                        match_d = '0;
                    end else if (match_q != MATCH_FULL) begin
                        match_d = match_q + MATCH_W'(1);
                    end
                    // An all-zero register trivially predicts a zero stream, so it may never lock
                    if (!mismatch && (match_d == MATCH_FULL) && (|sr_d)) begin
                        match_d = '0;
                        win_d   = '0;
                        werr_d  = '0;
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    sr_d      = {sr_q[WIDTH-2:0], pred};
                    bit_cnt_d = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
                    if (mismatch) begin
                        err_cnt_d   = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
                        err_pulse_d = 1'b1;
                    end
                    // Threshold takes priority over the window wrap on the same bit
                    if (werr_next == WERR_LIMIT) begin
                        state_d     = ST_SEED;
                        lol_pulse_d = 1'b1;
                        fill_d      = '0;
                        match_d     = '0;
                        win_d       = '0;
                        werr_d      = '0;
                    end else if (win_q == WIN_LAST) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = win_q + WIN_W'(1);
                        werr_d = werr_next;
                    end
                end
                default: begin
                    state_d = ST_SEED;
                    fill_d  = '0;
                    match_d = '0;
                end
            endcase
        end

        if (clear_cnt) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_SEED;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            lol_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
            lol_pulse_q <= lol_pulse_d;
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign err_pulse = err_pulse_q;
    assign lol_pulse = lol_pulse_q;
    assign bit_count = bit_cnt_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker_23b.sv
// Scoreboard bench for prbs_checker_23b: stimulus pushes expectations from a history-based
// reference model, a separate monitor pops and compares one entry per driven clock edge.
module tb_prbs_checker_23b;

    typedef struct {
        logic        locked;
        logic        errp;
        logic        lolp;
        logic [31:0] bitc;
        logic [31:0] errc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        shift_enable;
    logic        bit_in;
    logic        clear_cnt;
    logic        locked;
    logic        err_pulse;
    logic        lol_pulse;
    logic [31:0] bit_count;
    logic [31:0] err_count;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;

    int          gq[$];
    int          hist[$];
    int          acq_n;
    int          streak;
    int          win_pos;
    int          win_err;
    bit          m_locked;
    logic [31:0] m_bitc;
    logic [31:0] m_errc;

    prbs_checker_23b dut (
        .clk          (clk),
        .reset        (reset),
        .shift_enable (shift_enable),
        .bit_in       (bit_in),
        .clear_cnt    (clear_cnt),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .lol_pulse    (lol_pulse),
        .bit_count    (bit_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Generator: s[n] = s[n-23] ^ s[n-18], seeded with the newest bit 1 and the rest 0
    task automatic gen_reset();
        gq.delete();
        for (int i = 0; i < 22; i++) gq.push_back(0);
        gq.push_back(1);
    endtask

    function automatic int gen_next();
        int b;
        b = gq[0] ^ gq[5];
        void'(gq.pop_front());
        gq.push_back(b);
        return b;
    endfunction

    task automatic model_reset();
        hist.delete();
        acq_n    = 0;
        streak   = 0;
        win_pos  = 0;
        win_err  = 0;
        m_locked = 0;
        m_bitc   = '0;
        m_errc   = '0;
    endtask

    // Drives one clock of input and predicts the outputs after that edge
    task automatic apply_stimulus(input logic en, input logic b, input logic clr);
        exp_t e;
        int   pred;
        bit   nz;
        @(negedge clk);
        shift_enable = en;
        bit_in       = b;
        clear_cnt    = clr;
        e.errp = 1'b0;
        e.lolp = 1'b0;
        if (en) begin
            if (!m_locked) begin
                hist.push_back(int'(b));
                if (hist.size() > 24) void'(hist.pop_front());
                acq_n++;
                if (acq_n > 23) begin
                    pred   = hist[0] ^ hist[5];
                    streak = (int'(b) == pred) ? streak + 1 : 0;
                    nz = 1'b0;
                    for (int i = 1; i < 24; i++) if (hist[i] != 0) nz = 1'b1;
                    if (streak >= 64 && nz) begin
                        m_locked = 1'b1;
                        win_pos  = 0;
                        win_err  = 0;
                    end
                end
            end else begin
                pred = hist[1] ^ hist[6];
                hist.push_back(pred);
                void'(hist.pop_front());
                m_bitc = sat_inc(m_bitc);
                if (int'(b) != pred) begin
                    m_errc = sat_inc(m_errc);
                    e.errp = 1'b1;
                    win_err++;
                end
                if (win_err >= 16) begin
                    m_locked = 1'b0;
                    e.lolp   = 1'b1;
                    acq_n    = 0;
                    streak   = 0;
                end else begin
                    win_pos++;
                    if (win_pos == 256) begin
                        win_pos = 0;
                        win_err = 0;
                    end
                end
            end
        end
        if (clr) begin
            m_bitc = '0;
            m_errc = '0;
        end
        e.locked = m_locked;
        e.bitc   = m_bitc;
        e.errc   = m_errc;
        exp_q.push_back(e);
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'(gen_next()), 1'b0);
    endtask

    task automatic send_flip();
        apply_stimulus(1'b1, 1'(gen_next() ^ 1), 1'b0);
    endtask

    task automatic peek();
        @(posedge clk);
        #2;
    endtask

    task automatic async_reset();
        @(negedge clk);
        shift_enable = 1'b0;
        clear_cnt    = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_output("rst_locked", locked, 0);
        check_output("rst_err_pulse", err_pulse, 0);
        check_output("rst_lol_pulse", lol_pulse, 0);
        check_output("rst_bit_count", bit_count, 0);
        check_output("rst_err_count", err_count, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("locked", locked, e.locked);
                check_output("err_pulse", err_pulse, e.errp);
                check_output("lol_pulse", lol_pulse, e.lolp);
                check_output("bit_count", bit_count, e.bitc);
                check_output("err_count", err_count, e.errc);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : stimulus
        int gap;
        logic en;
        logic b;
        reset        = 1'b0;
        shift_enable = 1'b0;
        bit_in       = 1'b0;
        clear_cnt    = 1'b0;
        model_reset();
        gen_reset();
        #3;
        check_output("init_locked", locked, 0);
        check_output("init_bit_count", bit_count, 0);
        check_output("init_err_count", err_count, 0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] clean stream lock and count");
        send(86);
        peek();
        check_output("lock_not_before_87", locked, 0);
        send(1);
        peek();
        check_output("lock_at_87", locked, 1);
        send(10000);
        peek();
        check_output("clean_bit_count", bit_count, 10000);
        check_output("clean_err_count", err_count, 0);

        $display("[TB] single bit error");
        send_flip();
        peek();
        check_output("single_err_pulse", err_pulse, 1);
        send(300);
        peek();
        check_output("single_err_count", err_count, 1);
        check_output("single_still_locked", locked, 1);

        $display("[TB] loss of lock and relock");
        for (int i = 0; i < 300 && win_pos != 0; i++) send(1);
        for (int i = 0; i < 16; i++) begin
            gap = $urandom_range(0, 14);
            send(gap);
            send_flip();
        end
        peek();
        check_output("lol_pulse_at_16th", lol_pulse, 1);
        check_output("lol_unlocked", locked, 0);
        check_output("lol_err_count", err_count, 17);
        send(86);
        peek();
        check_output("relock_not_before_87", locked, 0);
        send(1);
        peek();
        check_output("relock_at_87", locked, 1);
        check_output("relock_err_count_kept", err_count, 17);

        $display("[TB] enable gap");
        send(50);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        send(50);
        peek();
        check_output("gap_bit_count", bit_count, m_bitc);
        check_output("gap_err_count", err_count, 17);

        $display("[TB] randomized enables, errors and clears");
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 4) != 0);
            if (en) begin
                b = 1'(gen_next());
                if ($urandom_range(0, 399) == 0) b = ~b;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            apply_stimulus(en, b, ($urandom_range(0, 499) == 0));
        end

        $display("[TB] asynchronous reset while locked");
        send(100);
        peek();
        check_output("pre_reset_locked", locked, 1);
        async_reset();
        send(86);
        peek();
        check_output("post_reset_not_locked", locked, 0);
        send(1);
        peek();
        check_output("post_reset_relock", locked, 1);
        check_output("post_reset_bit_count", bit_count, 0);
        send(40);
        apply_stimulus(1'b1, 1'(gen_next()), 1'b1);
        peek();
        check_output("clear_bit_count", bit_count, 0);
        check_output("clear_err_count", err_count, 0);
        check_output("clear_keeps_lock", locked, 1);
        send(10);

        $display("[TB] all-zero stream");
        async_reset();
        for (int i = 0; i < 1000; i++) apply_stimulus(1'b1, 1'b0, 1'b0);
        peek();
        check_output("zero_never_locks", locked, 0);
        check_output("zero_bit_count", bit_count, 0);
        check_output("zero_err_count", err_count, 0);

        shift_enable = 1'b0;
        @(posedge clk);
        #2;
        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
